// File: rtl/kws_pkg.sv
// Shared constants and FSM encoding for the KWS SRAM arbiter slice.
package kws_pkg;

    localparam int         SRAM_ADDR_W = 10;
    localparam int         SRAM_DATA_W = 32;
    localparam logic [3:0] WMASK_ALL   = 4'hF;

    typedef enum logic {
        ARB_S  = 1'b0,
        HACK_S = 1'b1
    } arb_state_e;

endpackage

// File: rtl/kws_starve_cnt.sv
// Saturating host wait counter; force_o lets the host beat the CNN once it has
// lost arbitration MAX_WAIT times in a row.
module kws_starve_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic lose_i,
    input  logic issue_i,
    output logic force_o
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || issue_i) begin
            cnt_d = '0;
        end else if (lose_i && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/kws_sram_arbiter.sv
// Shares the single-port weight/activation SRAM between the Wishbone host and
// the CNN engine; CNN has priority, host starvation is bounded by a wait counter.
module kws_sram_arbiter
    import kws_pkg::*;
#(
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [3:0]        host_sel,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              cnn_req,
    input  logic              cnn_we,
    input  logic [ADDR_W-1:0] cnn_addr,
    input  logic [DATA_W-1:0] cnn_wdata,
    output logic              cnn_gnt,
    output logic              cnn_rvalid,
    output logic [DATA_W-1:0] cnn_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [3:0]        sram_wmask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [15:0]       host_stall_cnt
);

    arb_state_e        state_q;
    logic              host_ack_q;
    logic              hread_q;
    logic              cnn_rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [15:0]       stall_q;

    logic host_busy, host_elig, host_win, host_lose, host_nop, force_host;

    // Gating with rst_n keeps the grant and strobes low for the whole reset.
    assign host_busy = (state_q == HACK_S);
    assign host_elig = rst_n & host_req & ~host_busy;
    assign host_win  = host_elig & (~cnn_req | force_host);
    assign host_lose = host_elig & ~host_win;
    assign cnn_gnt   = rst_n & cnn_req & ~host_win;
    assign host_nop  = host_we & (host_sel == 4'h0);

    kws_starve_cnt #(
        .MAX_WAIT (HOST_MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (host_req),
        .lose_i  (host_lose),
        .issue_i (host_win),
        .force_o (force_host)
    );

    always_comb begin
        sram_en = cnn_gnt | (host_win & ~host_nop);
        if (host_win) begin
            sram_we    = host_we;
            sram_wmask = host_sel;
            sram_addr  = host_addr;
            sram_wdata = host_wdata;
        end else begin
            sram_we    = cnn_we;
            sram_wmask = WMASK_ALL;
            sram_addr  = cnn_addr;
            sram_wdata = cnn_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_S;
            host_ack_q   <= 1'b0;
            hread_q      <= 1'b0;
            rdata_q      <= '0;
            cnn_rvalid_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            cnn_rvalid_q <= cnn_gnt & ~cnn_we;
            if (host_lose && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            case (state_q)
                ARB_S: begin
                    host_ack_q <= 1'b0;
                    if (host_win) begin
                        state_q    <= HACK_S;
                        host_ack_q <= 1'b1;
                        hread_q    <= ~host_we;
                    end
                end
                HACK_S: begin
                    state_q    <= ARB_S;
                    host_ack_q <= 1'b0;
                    if (hread_q) begin
                        rdata_q <= sram_rdata;
                    end
                end
                default: begin
                    state_q    <= ARB_S;
                    host_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Read data arrives from the macro in the ack cycle itself; rdata_q holds it after.
    assign host_ack       = host_ack_q;
    assign host_rdata     = (host_ack_q & hread_q) ? sram_rdata : rdata_q;
    assign cnn_rvalid     = cnn_rvalid_q;
    assign cnn_rdata      = sram_rdata;
    assign host_stall_cnt = stall_q;

endmodule
